mini_pipeline_hz: RTL and testbench

Parametrised successor to the fixed 4×64 mini load/store pipeline. It is a 5-stage IF/ID/EX/MEM/WB load/store core with run/step control and generic register-file and memory sizes. It adds RAW hazard interlock, a WB→ID bypass, a HALT instruction, a PC breakpoint and performance counters. It sits under the board-level programming/debug wrapper, which loads imem/dmem and observes the debug outputs.

---
 rtl/mini_pipe_pkg.sv | 35 +++
 rtl/mini_hazard_unit.sv | 41 ++++
 rtl/mini_pipeline_hz.sv | 235 +++++++++++++++++++++++
 tb/tb_mini_pipeline_hz.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_pipe_pkg.sv
// Shared definitions for the mini load/store pipeline: instruction field
// positions, the per-stage control bundle and the decoder.
package mini_pipe_pkg;

  localparam int INSTR_W     = 32;
  localparam int BIT_WMEM    = 31;
  localparam int BIT_WREG_EN = 30;
  localparam int REG1_LSB    = 27;
  localparam int REG2_LSB    = 24;
  localparam int WREG_LSB    = 21;
  localparam int BIT_HALT    = 20;
  localparam int REG_FIELD_W = 3;

  typedef struct packed {
    logic                   valid;
    logic                   wmem;
    logic                   wreg_en;
    logic [REG_FIELD_W-1:0] wreg;
    logic                   halt;
  } stage_ctrl_t;

  localparam stage_ctrl_t BUBBLE = '0;

  function automatic stage_ctrl_t decode_ctrl(input logic valid,
                                              input logic [INSTR_W-1:0] instr);
    stage_ctrl_t c;
    c.valid   = valid;
    c.wmem    = instr[BIT_WMEM];
    c.wreg_en = instr[BIT_WREG_EN];
    c.wreg    = instr[WREG_LSB +: REG_FIELD_W];
    c.halt    = instr[BIT_HALT];
    return c;
  endfunction

endpackage

// File: rtl/mini_hazard_unit.sv
// RAW interlock and WB->ID bypass selection for the instruction held in IF/ID.
// Purely combinational; the top decides what to do with the result.
module mini_hazard_unit
  import mini_pipe_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic              id_valid,
  input  logic              id_uses_r2,
  input  logic [REG_AW-1:0] id_r1,
  input  logic [REG_AW-1:0] id_r2,
  input  stage_ctrl_t       idex_ctrl,
  input  stage_ctrl_t       exmem_ctrl,
  input  stage_ctrl_t       mem_ctrl,
  input  stage_ctrl_t       wb_ctrl,
  output logic              interlock,
  output logic              byp_r1,
  output logic              byp_r2
);

  function automatic logic produces(input stage_ctrl_t c, input logic [REG_AW-1:0] r);
    return c.valid && c.wreg_en && (c.wreg[REG_AW-1:0] == r);
  endfunction

  logic r1_busy;
  logic r2_busy;
  logic unused_fields;

  // WB is deliberately absent here: its result reaches ID through the bypass.
  assign r1_busy = produces(idex_ctrl, id_r1) || produces(exmem_ctrl, id_r1) ||
                   produces(mem_ctrl, id_r1);
  assign r2_busy = produces(idex_ctrl, id_r2) || produces(exmem_ctrl, id_r2) ||
                   produces(mem_ctrl, id_r2);

  assign interlock = id_valid && (r1_busy || (id_uses_r2 && r2_busy));
  assign byp_r1    = produces(wb_ctrl, id_r1);
  assign byp_r2    = produces(wb_ctrl, id_r2);

  assign unused_fields = ^{idex_ctrl, exmem_ctrl, mem_ctrl, wb_ctrl};

endmodule

// File: rtl/mini_pipeline_hz.sv
// 5-stage IF/ID/EX/MEM/WB load/store core with run/step control, RAW interlock,
// WB->ID bypass, HALT, PC breakpoint and saturating performance counters.
module mini_pipeline_hz
  import mini_pipe_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int NREG    = 8,
  parameter int IMEM_AW = 9,
  parameter int DMEM_AW = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               pc_reset_pulse,
  input  logic               imem_prog_we,
  input  logic [IMEM_AW-1:0] imem_prog_addr,
  input  logic [31:0]        imem_prog_wdata,
  input  logic               dmem_prog_en,
  input  logic               dmem_prog_we,
  input  logic [DMEM_AW-1:0] dmem_prog_addr,
  input  logic [DATA_W-1:0]  dmem_prog_wdata,
  output logic [DATA_W-1:0]  dmem_prog_rdata,
  input  logic               bp_en,
  input  logic [IMEM_AW-1:0] bp_addr,
  output logic               halted,
  output logic [IMEM_AW-1:0] pc_dbg,
  output logic [31:0]        if_instr_dbg,
  output logic [CNT_W-1:0]   retired_cnt,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int REG_AW = $clog2(NREG);

  logic [INSTR_W-1:0] imem [2**IMEM_AW];
  logic [DATA_W-1:0]  dmem [2**DMEM_AW];
  logic [DATA_W-1:0]  rf   [NREG];

  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  stage_ctrl_t        idex_ctrl_q, idex_ctrl_d;
  logic [DATA_W-1:0]  idex_r1_q, idex_r1_d;
  logic [DATA_W-1:0]  idex_r2_q, idex_r2_d;
  stage_ctrl_t        exmem_ctrl_q, exmem_ctrl_d;
  logic [DMEM_AW-1:0] exmem_addr_q, exmem_addr_d;
  logic [DATA_W-1:0]  exmem_sdata_q, exmem_sdata_d;
  stage_ctrl_t        mem_ctrl_q, mem_ctrl_d;
  stage_ctrl_t        wb_ctrl_q, wb_ctrl_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic               halted_q, halted_d;
  logic               step_q, step_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic [DATA_W-1:0]  dmem_rdata_a_q;
  logic [DATA_W-1:0]  dmem_prog_rdata_q;

  logic [IMEM_AW-1:0] imem_addr;
  logic [INSTR_W-1:0] if_instr;
  logic               step_rise;
  logic               bp_hit;
  logic               advance;
  stage_ctrl_t        id_ctrl;
  logic [REG_AW-1:0]  id_r1, id_r2;
  logic [DATA_W-1:0]  id_r1_data, id_r2_data;
  logic               interlock, byp_r1, byp_r2;
  logic               rf_we;
  logic [REG_AW-1:0]  wb_wreg;
  logic               store_we;
  logic               halt_retire;
  logic               unused_bits;

  // Programming port borrows the single imem read address.
  assign imem_addr = imem_prog_we ? imem_prog_addr : pc_q;
  assign if_instr  = imem[imem_addr];

  // A breakpoint also blocks the advance so the matching instruction is never fetched.
  assign step_rise = step & ~step_q;
  assign bp_hit    = bp_en & (pc_q == bp_addr) & ~halted_q;
  assign advance   = (run | step_rise) & ~halted_q & ~imem_prog_we & ~bp_hit &
                     ~reset & ~pc_reset_pulse;

  assign id_ctrl    = decode_ctrl(ifid_valid_q, ifid_instr_q);
  assign id_r1      = ifid_instr_q[REG1_LSB +: REG_AW];
  assign id_r2      = ifid_instr_q[REG2_LSB +: REG_AW];
  assign id_r1_data = byp_r1 ? wb_data_q : rf[id_r1];
  assign id_r2_data = byp_r2 ? wb_data_q : rf[id_r2];

  mini_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .id_valid   (ifid_valid_q),
    .id_uses_r2 (id_ctrl.wmem),
    .id_r1      (id_r1),
    .id_r2      (id_r2),
    .idex_ctrl  (idex_ctrl_q),
    .exmem_ctrl (exmem_ctrl_q),
    .mem_ctrl   (mem_ctrl_q),
    .wb_ctrl    (wb_ctrl_q),
    .interlock  (interlock),
    .byp_r1     (byp_r1),
    .byp_r2     (byp_r2)
  );

  assign rf_we       = advance & wb_ctrl_q.valid & wb_ctrl_q.wreg_en;
  assign wb_wreg     = wb_ctrl_q.wreg[REG_AW-1:0];
  assign store_we    = advance & exmem_ctrl_q.valid & exmem_ctrl_q.wmem;
  assign halt_retire = advance & wb_ctrl_q.valid & wb_ctrl_q.halt;

  // NOTE: every variable gets its hold value first so no path through this block infers a latch.
  always_comb begin
    pc_d          = pc_q;
    ifid_valid_d  = ifid_valid_q;
    ifid_instr_d  = ifid_instr_q;
    idex_ctrl_d   = idex_ctrl_q;
    idex_r1_d     = idex_r1_q;
    idex_r2_d     = idex_r2_q;
    exmem_ctrl_d  = exmem_ctrl_q;
    exmem_addr_d  = exmem_addr_q;
    exmem_sdata_d = exmem_sdata_q;
    mem_ctrl_d    = mem_ctrl_q;
    wb_ctrl_d     = wb_ctrl_q;
    wb_data_d     = wb_data_q;
    halted_d      = halted_q | bp_hit | halt_retire;
    step_d        = step;
    retired_d     = retired_q;
    stall_d       = stall_q;

    if (advance) begin
      exmem_ctrl_d  = idex_ctrl_q;
      exmem_addr_d  = idex_r1_q[DMEM_AW-1:0];
      exmem_sdata_d = idex_r2_q;
      mem_ctrl_d    = exmem_ctrl_q;
      wb_ctrl_d     = mem_ctrl_q;
      wb_data_d     = dmem_rdata_a_q;
      if (interlock) begin
        idex_ctrl_d = BUBBLE;
        if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
      end else begin
        pc_d         = pc_q + IMEM_AW'(1);
        ifid_valid_d = 1'b1;
        ifid_instr_d = if_instr;
        idex_ctrl_d  = id_ctrl;
        idex_r1_d    = id_r1_data;
        idex_r2_d    = id_r2_data;
      end
      if (wb_ctrl_q.valid && retired_q != '1) retired_d = retired_q + CNT_W'(1);
    end

    if (pc_reset_pulse) begin
      pc_d         = '0;
      ifid_valid_d = 1'b0;
      idex_ctrl_d  = BUBBLE;
      exmem_ctrl_d = BUBBLE;
      mem_ctrl_d   = BUBBLE;
      wb_ctrl_d    = BUBBLE;
      halted_d     = 1'b0;
      step_d       = 1'b0;
      retired_d    = '0;
      stall_d      = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= '0;
      ifid_valid_q  <= 1'b0;
      ifid_instr_q  <= '0;
      idex_ctrl_q   <= BUBBLE;
      idex_r1_q     <= '0;
      idex_r2_q     <= '0;
      exmem_ctrl_q  <= BUBBLE;
      exmem_addr_q  <= '0;
      exmem_sdata_q <= '0;
      mem_ctrl_q    <= BUBBLE;
      wb_ctrl_q     <= BUBBLE;
      wb_data_q     <= '0;
      halted_q      <= 1'b0;
      step_q        <= 1'b0;
      retired_q     <= '0;
      stall_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      ifid_valid_q  <= ifid_valid_d;
      ifid_instr_q  <= ifid_instr_d;
      idex_ctrl_q   <= idex_ctrl_d;
      idex_r1_q     <= idex_r1_d;
      idex_r2_q     <= idex_r2_d;
      exmem_ctrl_q  <= exmem_ctrl_d;
      exmem_addr_q  <= exmem_addr_d;
      exmem_sdata_q <= exmem_sdata_d;
      mem_ctrl_q    <= mem_ctrl_d;
      wb_ctrl_q     <= wb_ctrl_d;
      wb_data_q     <= wb_data_d;
      halted_q      <= halted_d;
      step_q        <= step_d;
      retired_q     <= retired_d;
      stall_q       <= stall_d;
    end
  end

  // NOTE: the register file is small enough to clear on reset; imem and dmem are RAMs and keep contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (rf_we) begin
      rf[wb_wreg] <= wb_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_prog_we) imem[imem_prog_addr] <= imem_prog_wdata;
  end

  // Port A is written after port B so it wins an address collision; both ports read-first.
  always_ff @(posedge clk) begin
    if (dmem_prog_en) begin
      if (dmem_prog_we) dmem[dmem_prog_addr] <= dmem_prog_wdata;
      dmem_prog_rdata_q <= dmem[dmem_prog_addr];
    end
    if (advance) dmem_rdata_a_q <= dmem[exmem_addr_q];
    if (store_we) dmem[exmem_addr_q] <= exmem_sdata_q;
  end

  assign unused_bits = ^{ifid_instr_q, idex_r1_q, wb_ctrl_q};

  assign dmem_prog_rdata = dmem_prog_rdata_q;
  assign halted          = halted_q;
  assign pc_dbg          = pc_q;
  assign if_instr_dbg    = if_instr;
  assign retired_cnt     = retired_q;
  assign stall_cnt       = stall_q;

endmodule

// File: tb/tb_mini_pipeline_hz.sv
// Directed self-checking bench for mini_pipeline_hz: loads, RAW stalls, bypass,
// step mode, HALT, breakpoint and flush of an in-flight store.
module tb_mini_pipeline_hz;

  localparam int DATA_W  = 64;
  localparam int NREG    = 8;
  localparam int IMEM_AW = 9;
  localparam int DMEM_AW = 8;
  localparam int CNT_W   = 32;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] HALT_I = 32'h0010_0000;

  logic               clk = 1'b0;
  logic               reset, run, step, pc_reset_pulse;
  logic               imem_prog_we;
  logic [IMEM_AW-1:0] imem_prog_addr;
  logic [31:0]        imem_prog_wdata;
  logic               dmem_prog_en, dmem_prog_we;
  logic [DMEM_AW-1:0] dmem_prog_addr;
  logic [DATA_W-1:0]  dmem_prog_wdata, dmem_prog_rdata;
  logic               bp_en;
  logic [IMEM_AW-1:0] bp_addr;
  logic               halted;
  logic [IMEM_AW-1:0] pc_dbg;
  logic [31:0]        if_instr_dbg;
  logic [CNT_W-1:0]   retired_cnt, stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] rd;

  always #5 clk = ~clk;

  mini_pipeline_hz #(
    .DATA_W(DATA_W), .NREG(NREG), .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .CNT_W(CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .run             (run),
    .step            (step),
    .pc_reset_pulse  (pc_reset_pulse),
    .imem_prog_we    (imem_prog_we),
    .imem_prog_addr  (imem_prog_addr),
    .imem_prog_wdata (imem_prog_wdata),
    .dmem_prog_en    (dmem_prog_en),
    .dmem_prog_we    (dmem_prog_we),
    .dmem_prog_addr  (dmem_prog_addr),
    .dmem_prog_wdata (dmem_prog_wdata),
    .dmem_prog_rdata (dmem_prog_rdata),
    .bp_en           (bp_en),
    .bp_addr         (bp_addr),
    .halted          (halted),
    .pc_dbg          (pc_dbg),
    .if_instr_dbg    (if_instr_dbg),
    .retired_cnt     (retired_cnt),
    .stall_cnt       (stall_cnt)
  );

  function automatic logic [31:0] ld(input int w, input int a);
    return {1'b0, 1'b1, 3'(a), 3'b000, 3'(w), 1'b0, 20'h0};
  endfunction

  function automatic logic [31:0] st(input int a, input int b);
    return {1'b1, 1'b0, 3'(a), 3'(b), 3'b000, 1'b0, 20'h0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_imem(input int a, input logic [31:0] d);
    imem_prog_we = 1'b1; imem_prog_addr = IMEM_AW'(a); imem_prog_wdata = d;
    cycles(1);
    imem_prog_we = 1'b0;
  endtask

  task automatic put_dmem(input int a, input logic [63:0] d);
    dmem_prog_en = 1'b1; dmem_prog_we = 1'b1; dmem_prog_addr = DMEM_AW'(a); dmem_prog_wdata = d;
    cycles(1);
    dmem_prog_en = 1'b0; dmem_prog_we = 1'b0;
  endtask

  task automatic get_dmem(input int a, output logic [63:0] d);
    dmem_prog_en = 1'b1; dmem_prog_we = 1'b0; dmem_prog_addr = DMEM_AW'(a);
    cycles(1);
    dmem_prog_en = 1'b0;
    d = dmem_prog_rdata;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) put_imem(i, NOP);
  endtask

  task automatic flush();
    pc_reset_pulse = 1'b1;
    cycles(1);
    pc_reset_pulse = 1'b0;
  endtask

  task automatic run_for(input int n);
    run = 1'b1;
    cycles(n);
    run = 1'b0;
  endtask

  task automatic step_pulse();
    step = 1'b1;
    cycles(1);
    step = 1'b0;
    cycles(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; pc_reset_pulse = 1'b0;
    imem_prog_we = 1'b0; imem_prog_addr = '0; imem_prog_wdata = '0;
    dmem_prog_en = 1'b0; dmem_prog_we = 1'b0; dmem_prog_addr = '0; dmem_prog_wdata = '0;
    bp_en = 1'b0; bp_addr = '0;
    cycles(3);
    reset = 1'b0;
    cycles(1);

    check("reset_pc", 64'(pc_dbg), 64'd0);
    check("reset_halted", 64'(halted), 64'd0);
    check("reset_retired", 64'(retired_cnt), 64'd0);
    check("reset_stall", 64'(stall_cnt), 64'd0);

    for (int i = 0; i < 2**IMEM_AW; i++) put_imem(i, NOP);
    for (int i = 0; i < 2**DMEM_AW; i++) put_dmem(i, 64'd0);

    // Independent loads plus a distance-4 consumer fed through the bypass.
    put_dmem(0, 64'd5);
    put_dmem(5, 64'hAA);
    put_dmem(6, 64'hBB);
    put_imem(0, ld(1, 0));
    put_imem(1, ld(3, 0));
    put_imem(4, ld(2, 1));
    put_imem(8, st(2, 1));
    flush();
    run_for(20);
    check("t1_stall", 64'(stall_cnt), 64'd0);
    check("t1_retired", 64'(retired_cnt), 64'd15);
    check("t1_pc", 64'(pc_dbg), 64'd20);
    get_dmem(8'hAA, rd);
    check("t1_bypass_store", rd, 64'd5);
    get_dmem(0, rd);
    check("t1_dmem0_kept", rd, 64'd5);

    // Back-to-back RAW: the store address comes from the load just before it.
    clear_prog();
    put_dmem(5, 64'h33);
    put_imem(0, ld(1, 0));
    put_imem(1, ld(3, 0));
    put_imem(4, ld(2, 1));
    put_imem(5, st(2, 3));
    flush();
    run_for(30);
    check("t2_stall_d1", 64'(stall_cnt), 64'd3);
    check("t2_retired_d1", 64'(retired_cnt), 64'd22);
    get_dmem(8'h33, rd);
    check("t2_store_d1", rd, 64'd5);

    // Same dependency at distance 2.
    clear_prog();
    put_dmem(5, 64'h44);
    put_imem(0, ld(1, 0));
    put_imem(1, ld(3, 0));
    put_imem(4, ld(2, 1));
    put_imem(6, st(2, 3));
    flush();
    run_for(30);
    check("t2_stall_d2", 64'(stall_cnt), 64'd2);
    get_dmem(8'h44, rd);
    check("t2_store_d2", rd, 64'd5);

    // Step mode: a held step is one advance, then three separate pulses.
    clear_prog();
    flush();
    step = 1'b1;
    cycles(10);
    step = 1'b0;
    cycles(1);
    check("t4_step_hold_pc", 64'(pc_dbg), 64'd1);
    repeat (3) step_pulse();
    check("t4_step_pc", 64'(pc_dbg), 64'd4);
    step_pulse();
    check("t4_retired_after5", 64'(retired_cnt), 64'd0);
    step_pulse();
    check("t4_retired_after6", 64'(retired_cnt), 64'd1);

    // HALT at pc 7; the store at pc 13 must never execute.
    clear_prog();
    put_imem(7, HALT_I);
    put_imem(13, st(0, 2));
    flush();
    run_for(40);
    check("t5_halted", 64'(halted), 64'd1);
    check("t5_retired", 64'(retired_cnt), 64'd8);
    check("t5_pc", 64'(pc_dbg), 64'd13);
    run_for(10);
    check("t5_pc_frozen", 64'(pc_dbg), 64'd13);
    get_dmem(0, rd);
    check("t5_no_store", rd, 64'd5);
    flush();
    check("t5_unhalt", 64'(halted), 64'd0);
    check("t5_unhalt_pc", 64'(pc_dbg), 64'd0);

    // Breakpoint at pc 3.
    bp_en = 1'b1;
    bp_addr = IMEM_AW'(3);
    run_for(10);
    check("t5_bp_halted", 64'(halted), 64'd1);
    check("t5_bp_pc", 64'(pc_dbg), 64'd3);
    bp_en = 1'b0;
    flush();
    check("t5_bp_clear", 64'(halted), 64'd0);

    // Flush while a store sits in EX/MEM, with run high on the flush cycle.
    clear_prog();
    put_dmem(5, 64'h77);
    put_imem(0, st(1, 2));
    flush();
    repeat (3) step_pulse();
    run = 1'b1;
    pc_reset_pulse = 1'b1;
    cycles(1);
    run = 1'b0;
    pc_reset_pulse = 1'b0;
    check("t6_pc", 64'(pc_dbg), 64'd0);
    get_dmem(5, rd);
    check("t6_no_write", rd, 64'h77);
    run_for(15);
    get_dmem(5, rd);
    check("t6_rf_kept", rd, 64'h44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
